// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register-dependency scoreboard: class encodings,
// default counter width and the number of registers per file.
// Imported by sb_counter and reg_scoreboard.
package reg_scoreboard_pkg;

    localparam int SB_CNTW     = 2;
    localparam int SB_NUM_REGS = 8;
    localparam int SB_NUM_CLS  = 3;

    localparam logic [1:0] SB_CLS_GPR  = 2'b00;
    localparam logic [1:0] SB_CLS_SEG  = 2'b01;
    localparam logic [1:0] SB_CLS_MMX  = 2'b10;
    localparam logic [1:0] SB_CLS_NONE = 2'b11;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: pending-write counter for a single architectural register.
// Ports: clk/reset (sync, active-high), clr (flush), inc (issue), dec (writeback);
//        busy/full from the registered count, underflow pulse when dec hits an empty entry.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNTW = SB_CNTW
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic full,
    output logic underflow
);

    logic [CNTW-1:0] r_cnt;
    logic            w_inc_only;
    logic            w_dec_only;

    assign w_inc_only = inc & ~dec;
    assign w_dec_only = dec & ~inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_inc_only) begin
            r_cnt <= r_cnt + CNTW'(1);
        end else if (w_dec_only && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

    assign busy = (r_cnt != '0);
    assign full = &r_cnt;
    // A flush or reset wipes the entry anyway, so a stray writeback in that
    // cycle is not reported as an underflow.
    assign underflow = ~reset & ~clr & w_dec_only & ~busy;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard gating decode -> register access (GPR/SEG/MMX).
// Ports: in_valid/in_ready and out_valid/out_ready handshake, src/dst operand
//        descriptors, per-file writeback strobes, busy_* maps, stall, sticky err_underflow.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int CNTW = SB_CNTW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       src0_en,
    input  logic [1:0] src0_cls,
    input  logic [2:0] src0_num,
    input  logic       src1_en,
    input  logic [1:0] src1_cls,
    input  logic [2:0] src1_num,
    input  logic       dst_en,
    input  logic [1:0] dst_cls,
    input  logic [2:0] dst_num,
    input  logic       wb_reg_en,
    input  logic [2:0] wb_reg_number,
    input  logic       wb_seg_en,
    input  logic [2:0] wb_seg_number,
    input  logic       wb_mmx_en,
    input  logic [2:0] wb_mmx_number,
    output logic [7:0] busy_gpr,
    output logic [7:0] busy_seg,
    output logic [7:0] busy_mmx,
    output logic       stall,
    output logic       err_underflow
);

    localparam int NENT = SB_NUM_CLS * SB_NUM_REGS;

    logic [NENT-1:0] w_busy;
    logic [NENT-1:0] w_full;
    logic [NENT-1:0] w_uflow;
    // Padded to 32 entries so {cls,num} indexes directly; class NONE lands in
    // the zero padding and therefore never hazards.
    logic [31:0]     w_busy_pad;
    logic [31:0]     w_full_pad;
    logic [2:0]      w_wb_en;
    logic [2:0]      w_wb_num [SB_NUM_CLS];
    logic            w_hazard;
    logic            w_fire;
    logic            r_err_underflow;

    assign w_wb_en     = {wb_mmx_en, wb_seg_en, wb_reg_en};
    assign w_wb_num[0] = wb_reg_number;
    assign w_wb_num[1] = wb_seg_number;
    assign w_wb_num[2] = wb_mmx_number;

    assign w_busy_pad = {{(32-NENT){1'b0}}, w_busy};
    assign w_full_pad = {{(32-NENT){1'b0}}, w_full};

    assign w_hazard = (src0_en & w_busy_pad[{src0_cls, src0_num}])
                    | (src1_en & w_busy_pad[{src1_cls, src1_num}])
                    | (dst_en  & w_full_pad[{dst_cls,  dst_num}]);

    assign out_valid = in_valid  & ~w_hazard & ~flush;
    assign in_ready  = out_ready & ~w_hazard & ~flush;
    assign stall     = in_valid  & w_hazard;
    assign w_fire    = in_valid  & in_ready;

    for (genvar c = 0; c < SB_NUM_CLS; c++) begin : g_cls
        localparam logic [1:0] LCLS = 2'(c);
        for (genvar n = 0; n < SB_NUM_REGS; n++) begin : g_reg
            localparam logic [2:0] LNUM = 3'(n);
            logic w_inc;
            logic w_dec;

            assign w_inc = w_fire & dst_en & (dst_cls == LCLS) & (dst_num == LNUM);
            assign w_dec = w_wb_en[c] & (w_wb_num[c] == LNUM);

            sb_counter #(.CNTW(CNTW)) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .clr       (flush),
                .inc       (w_inc),
                .dec       (w_dec),
                .busy      (w_busy[c*SB_NUM_REGS + n]),
                .full      (w_full[c*SB_NUM_REGS + n]),
                .underflow (w_uflow[c*SB_NUM_REGS + n])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_underflow <= 1'b0;
        end else if (|w_uflow) begin
            r_err_underflow <= 1'b1;
        end
    end

    assign err_underflow = r_err_underflow;
    assign busy_gpr      = w_busy[7:0];
    assign busy_seg      = w_busy[15:8];
    assign busy_mmx      = w_busy[23:16];

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios then random traffic,
// all compared against a counter-array reference model.
// Ports: none (top-level bench).
module tb_reg_scoreboard;

    localparam int MAXC = 3;  // 2^CNTW - 1 with CNTW = 2

    logic       clk;
    logic       reset, flush, in_valid, out_ready;
    logic       in_ready, out_valid, stall, err_underflow;
    logic       src0_en, src1_en, dst_en;
    logic [1:0] src0_cls, src1_cls, dst_cls;
    logic [2:0] src0_num, src1_num, dst_num;
    logic       wb_reg_en, wb_seg_en, wb_mmx_en;
    logic [2:0] wb_reg_number, wb_seg_number, wb_mmx_number;
    logic [7:0] busy_gpr, busy_seg, busy_mmx;

    int cnt [3][8];
    bit m_err;
    int n_cmp = 0;
    int n_bad = 0;

    reg_scoreboard #(.CNTW(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .src0_en(src0_en), .src0_cls(src0_cls), .src0_num(src0_num),
        .src1_en(src1_en), .src1_cls(src1_cls), .src1_num(src1_num),
        .dst_en(dst_en), .dst_cls(dst_cls), .dst_num(dst_num),
        .wb_reg_en(wb_reg_en), .wb_reg_number(wb_reg_number),
        .wb_seg_en(wb_seg_en), .wb_seg_number(wb_seg_number),
        .wb_mmx_en(wb_mmx_en), .wb_mmx_number(wb_mmx_number),
        .busy_gpr(busy_gpr), .busy_seg(busy_seg), .busy_mmx(busy_mmx),
        .stall(stall), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy(input logic en, input logic [1:0] cls, input logic [2:0] num);
        if (!en || cls == 2'b11) return 1'b0;
        return cnt[cls][num] != 0;
    endfunction

    function automatic bit m_full(input logic en, input logic [1:0] cls, input logic [2:0] num);
        if (!en || cls == 2'b11) return 1'b0;
        return cnt[cls][num] == MAXC;
    endfunction

    function automatic logic [7:0] m_map(input int c);
        logic [7:0] v = '0;
        for (int n = 0; n < 8; n++) v[n] = (cnt[c][n] != 0);
        return v;
    endfunction

    task automatic idle();
        reset = 0; flush = 0; in_valid = 0; out_ready = 1;
        src0_en = 0; src0_cls = 2'b11; src0_num = 0;
        src1_en = 0; src1_cls = 2'b11; src1_num = 0;
        dst_en = 0;  dst_cls = 2'b11;  dst_num = 0;
        wb_reg_en = 0; wb_reg_number = 0;
        wb_seg_en = 0; wb_seg_number = 0;
        wb_mmx_en = 0; wb_mmx_number = 0;
    endtask

    task automatic set_dst(input logic [1:0] cls, input logic [2:0] num);
        in_valid = 1; dst_en = 1; dst_cls = cls; dst_num = num;
    endtask

    // Check combinational outputs and busy maps against the model, then advance
    // the model by one clock using the currently driven inputs.
    task automatic step();
        bit hz, fire, inc, dec, wen;
        logic [2:0] wnum;
        #2;
        hz = m_busy(src0_en, src0_cls, src0_num) | m_busy(src1_en, src1_cls, src1_num)
           | m_full(dst_en, dst_cls, dst_num);
        check("out_valid", out_valid, in_valid & ~hz & ~flush);
        check("in_ready",  in_ready,  out_ready & ~hz & ~flush);
        check("stall",     stall,     in_valid & hz);
        check("busy_gpr",  busy_gpr,  m_map(0));
        check("busy_seg",  busy_seg,  m_map(1));
        check("busy_mmx",  busy_mmx,  m_map(2));
        check("err",       err_underflow, m_err);
        fire = in_valid & out_ready & ~hz & ~flush;
        if (reset) begin
            foreach (cnt[c, n]) cnt[c][n] = 0;
            m_err = 0;
        end else if (flush) begin
            foreach (cnt[c, n]) cnt[c][n] = 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                wen  = (c == 0) ? wb_reg_en : (c == 1) ? wb_seg_en : wb_mmx_en;
                wnum = (c == 0) ? wb_reg_number : (c == 1) ? wb_seg_number : wb_mmx_number;
                for (int n = 0; n < 8; n++) begin
                    inc = fire && dst_en && dst_cls == 2'(c) && dst_num == 3'(n);
                    dec = wen && wnum == 3'(n);
                    if (inc && !dec) cnt[c][n]++;
                    else if (dec && !inc) begin
                        if (cnt[c][n] == 0) m_err = 1;
                        else cnt[c][n]--;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; step(); reset = 0;
    endtask

    function automatic logic [2:0] pick_wb(input int c);
        logic [2:0] n;
        for (int t = 0; t < 6; t++) begin
            n = 3'($urandom_range(0, 7));
            if (cnt[c][n] != 0) return n;
        end
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        foreach (cnt[c, n]) cnt[c][n] = 0;
        m_err = 0;
        reset = 0;

        // Reset state: outputs follow the formulas with empty counters.
        in_valid = 1; out_ready = 1;
        #2;
        check("rst_busy_gpr", busy_gpr, 8'h00);
        check("rst_err", err_underflow, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_stall", stall, 1'b0);
        idle();
        step();

        // add eax <- ebx, then a consumer of eax.
        idle(); set_dst(2'b00, 3'd0); src0_en = 1; src0_cls = 2'b00; src0_num = 3'd3;
        step();
        check("tp1_busy", busy_gpr, 8'h01);
        idle(); set_dst(2'b00, 3'd2); src0_en = 1; src0_cls = 2'b00; src0_num = 3'd0;
        #2; check("tp1_stall", stall, 1'b1); check("tp1_rdy", in_ready, 1'b0);
        step();
        wb_reg_en = 1; wb_reg_number = 3'd0;
        #2; check("tp1_nobypass", stall, 1'b1);
        step();
        wb_reg_en = 0;
        #2; check("tp1_go", in_ready, 1'b1);
        step();
        check("tp1_busy2", busy_gpr, 8'h04);

        // Saturating a GPR3 counter.
        do_reset();
        for (int i = 0; i < 3; i++) begin idle(); set_dst(2'b00, 3'd3); step(); end
        idle(); set_dst(2'b00, 3'd3);
        #2; check("tp2_full", stall, 1'b1);
        step();
        wb_reg_en = 1; wb_reg_number = 3'd3;
        #2; check("tp2_full_wb", stall, 1'b1);
        step();
        wb_reg_en = 0;
        #2; check("tp2_go", in_ready, 1'b1);
        step();
        #2; check("tp2_full2", stall, 1'b1);
        step();

        // Simultaneous inc and dec on MMX2.
        do_reset();
        idle(); set_dst(2'b10, 3'd2); step();
        wb_mmx_en = 1; wb_mmx_number = 3'd2; step();
        check("tp3_hold", busy_mmx, 8'h04);
        idle(); wb_mmx_en = 1; wb_mmx_number = 3'd2; step();
        check("tp3_one", busy_mmx, 8'h00);

        // Flush with pending writes.
        do_reset();
        idle(); set_dst(2'b00, 3'd1); step();
        idle(); set_dst(2'b01, 3'd2); step();
        idle(); set_dst(2'b10, 3'd5); step();
        idle(); set_dst(2'b00, 3'd0); flush = 1;
        #2; check("tp4_rdy", in_ready, 1'b0); check("tp4_vld", out_valid, 1'b0);
        step();
        idle();
        #2;
        check("tp4_gpr", busy_gpr, 8'h00);
        check("tp4_seg", busy_seg, 8'h00);
        check("tp4_mmx", busy_mmx, 8'h00);

        // Underflow is sticky across flush, cleared by reset.
        idle(); wb_seg_en = 1; wb_seg_number = 3'd4; step();
        check("tp5_err", err_underflow, 1'b1);
        idle(); flush = 1; step();
        check("tp5_err_flush", err_underflow, 1'b1);
        do_reset();
        check("tp5_err_rst", err_underflow, 1'b0);

        // Downstream backpressure without hazard.
        idle(); set_dst(2'b00, 3'd6); out_ready = 0;
        #2; check("tp6_rdy", in_ready, 1'b0); check("tp6_vld", out_valid, 1'b1);
        step();
        check("tp6_nochg", busy_gpr, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            idle();
            reset     = ($urandom_range(0, 149) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            src0_en = 1'($urandom); src0_cls = 2'($urandom); src0_num = 3'($urandom_range(0, 3));
            src1_en = 1'($urandom); src1_cls = 2'($urandom); src1_num = 3'($urandom_range(0, 3));
            dst_en  = ($urandom_range(0, 3) != 0);
            dst_cls = 2'($urandom); dst_num = 3'($urandom_range(0, 3));
            wb_reg_en = ($urandom_range(0, 2) == 0); wb_reg_number = pick_wb(0);
            wb_seg_en = ($urandom_range(0, 2) == 0); wb_seg_number = pick_wb(1);
            wb_mmx_en = ($urandom_range(0, 2) == 0); wb_mmx_number = pick_wb(2);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-dependency scoreboard between decode and register access in the x86 pipeline. It tracks pending writes to the GPR, segment and MMX files for instructions that have left decode but not yet written back. It gates the decode→register-access valid/ready handshake so no instruction reads a stale source. No instruction payload is stored; it only gates the handshake and keeps per-register pending counters.

## Interface
- CNTW, 2, width of each per-register pending counter; at most 2^CNTW−1 in-flight writes per register.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all counters and the error flag.
- flush  in  1  pipeline flush; clears all counters at the next edge and blocks issue this cycle.
- in_valid  in  1  decode output valid.
- in_ready  out  1  ready returned to decode.
- out_valid  out  1  valid forwarded to register access.
- out_ready  in  1  ready from register access.
- src0_en, src1_en  in  1 each  source operand uses a register.
- src0_cls, src1_cls  in  2 each  register class: 00 GPR, 01 SEG, 10 MMX, 11 none.
- src0_num, src1_num  in  3 each  register number.
- dst_en  in  1  instruction writes a register.
- dst_cls  in  2  destination class, same encoding.
- dst_num  in  3  destination number.
- wb_reg_en, wb_seg_en, wb_mmx_en  in  1 each  writeback strobes, one per file; may be concurrent.
- wb_reg_number, wb_seg_number, wb_mmx_number  in  3 each  writeback register numbers.
- busy_gpr, busy_seg, busy_mmx  out  8 each  bit i = counter i nonzero.
- stall  out  1  in_valid & hazard, for performance counters.
- err_underflow  out  1  sticky; a writeback arrived for a register with zero pending writes.

## Operation
- 24 counters: GPR[0..7], SEG[0..7], MMX[0..7]. Seg numbers 6–7 are tracked but never legitimately written.
- Class 11, or a cleared enable bit, means no register. Such an operand never hazards and never counts.
- busy(x) = counter(x) ≠ 0. full(x) = counter(x) = 2^CNTW−1. Both use registered counter values only; there is no writeback bypass.
- hazard = (src0_en & busy(src0)) | (src1_en & busy(src1)) | (dst_en & full(dst)).
- A destination that is busy but not full does not stall (WAW allowed); the counter accumulates.
- out_valid = in_valid & ~hazard & ~flush.
- in_ready = out_ready & ~hazard & ~flush.
- fire = in_valid & in_ready.
- Counter update per entry:
  - inc = fire & dst_en & dst matches the entry.
  - dec = a writeback strobe for the entry's class with a matching number.
  - inc & dec: hold.
  - inc only: +1.
  - dec only: −1, except at 0, where the counter holds and err_underflow is set.
- Priority order: reset > flush (all counters 0; err_underflow unchanged) > inc/dec.
- err_underflow clears only on reset.

## Timing
- Zero-latency handshake gating: out_valid, in_ready and stall are combinational from inputs and counters.
- A writeback at edge N makes the register non-busy for issue evaluation in cycle N+1. This matches the register file write at edge N.
- An issue at edge N makes the destination busy from cycle N+1.
- Reset values: all counters 0, busy_* = 0, err_underflow = 0.
- Output values then follow the formulas: in_ready = out_ready, out_valid = in_valid, stall = 0.
- Reset or flush mid-stream: in-flight writebacks arriving after a flush decrement zero counters. The underflow rule applies, so flush must also squash downstream writebacks.

## Structure
- Shared package holds the class encodings SB_CLS_GPR/SEG/MMX/NONE and the CNTW default.
- Sub-module sb_counter holds one entry: inputs inc, dec, clr; outputs busy, full, underflow pulse.
- sb_counter is instantiated 24 times. Top level does matching, the hazard OR-tree and the sticky error.

## Test plan
- Issue `add eax←ebx` (dst GPR0), out_ready = 1:
  - busy_gpr = 0x01 next cycle.
  - A following src GPR0 instruction stalls: stall = 1, in_ready = 0.
  - wb_reg_en with number 0 → issue proceeds the cycle after the writeback.
- Three back-to-back writes to GPR3 with CNTW = 2:
  - The counter reaches 3.
  - A fourth dst GPR3 stalls until one wb_reg_en with number 3 arrives.
- Issue dst MMX2 in the same cycle as wb_mmx_en with number 2 while the counter = 1 → the counter stays 1 and busy_mmx = 0x04.
- Pending GPR1, SEG2, MMX5, then assert flush → all busy_* = 0 next cycle, and in_ready = 0 during the flush cycle.
- wb_seg_en with number 4 while its counter = 0 → err_underflow = 1 and stays 1 through a flush. It returns to 0 only after reset.
- out_ready = 0 with no hazard → in_ready = 0, out_valid = in_valid, no counter change.
